// File: rtl/dirty_flusher.sv
// Flush sequencer for the per-cylinder write cache: walks the dirty-sector
// bitmap lowest-index first, writes each dirty sector to storage, then clears its bit.
module dirty_flusher #(
    parameter int NSECT     = 64,
    parameter int SADDR_W   = 6,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NSECT-1:0]   dirty_sectors,
    input  logic               all_clean,
    output logic               flush_req,
    output logic [SADDR_W-1:0] flush_saddr,
    input  logic               flush_ack,
    input  logic               flush_err,
    output logic               clr_en,
    output logic               clr_d,
    output logic [SADDR_W-1:0] clr_saddr,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [SADDR_W:0]   flushed_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEL  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_CLR  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [SADDR_W-1:0] saddr_q, saddr_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic               gap_q, gap_d;
    logic               abort_q, abort_d;
    logic               error_q, error_d;
    logic [SADDR_W:0]   cnt_q, cnt_d;

    logic [SADDR_W-1:0] low_idx;
    logic               found;

    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NSECT; i++) begin
            if (!found && dirty_sectors[i]) begin
                low_idx = SADDR_W'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        saddr_d = saddr_q;
        retry_d = retry_q;
        gap_d   = gap_q;
        abort_d = abort_q;
        error_d = error_q;
        cnt_d   = cnt_q;

        // An abort seen mid-flush is held until the next sector selection.
        if (state_q != S_IDLE && abort)
            abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d = S_SEL;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_SEL: begin
                gap_d = 1'b0;
                if (all_clean || abort || abort_q) begin
                    state_d = S_FIN;
                end else begin
                    saddr_d = low_idx;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (flush_ack) begin
                    if (!flush_err) begin
                        state_d = S_CLR;
                        retry_d = '0;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_CLR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_SEL;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            saddr_q <= '0;
            retry_q <= '0;
            gap_q   <= 1'b0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saddr_q <= saddr_d;
            retry_q <= retry_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush_req   = (state_q == S_REQ) && !gap_q;
    assign flush_saddr = saddr_q;
    assign clr_en      = (state_q == S_CLR);
    assign clr_d       = 1'b0;
    assign clr_saddr   = saddr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign error       = error_q;
    assign flushed_cnt = cnt_q;

endmodule

// File: tb/tb_dirty_flusher.sv
// Directed bench for dirty_flusher with a behavioural tracker and storage responder.
module tb_dirty_flusher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] map = '0;
    logic        all_clean;
    logic        flush_req;
    logic [5:0]  flush_saddr;
    logic        flush_ack = 1'b0;
    logic        flush_err = 1'b0;
    logic        clr_en;
    logic        clr_d;
    logic [5:0]  clr_saddr;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  flushed_cnt;

    assign all_clean = ~|map;

    always #5 clk = ~clk;

    dirty_flusher #(.NSECT(64), .SADDR_W(6), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dirty_sectors(map), .all_clean(all_clean),
        .flush_req(flush_req), .flush_saddr(flush_saddr),
        .flush_ack(flush_ack), .flush_err(flush_err),
        .clr_en(clr_en), .clr_d(clr_d), .clr_saddr(clr_saddr),
        .busy(busy), .done(done), .error(error), .flushed_cnt(flushed_cnt)
    );

    typedef struct {
        logic [63:0] map;
        int          delay;
        logic [2:0]  errs;
        int          abort_at;
        bit          force_ack;
        int          restart;
        int          exp_reqs;
        logic [5:0]  exp_first;
        logic [5:0]  exp_last;
        logic [6:0]  exp_cnt;
        bit          exp_error;
        int          exp_lat;
        logic [63:0] exp_map;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          cur_delay = 0;
    logic [2:0]  cur_errs = '0;
    int          cur_abort_at = 0;
    bit          force_ack = 1'b0;
    int nreq, nclr, ack_idx, wait_cnt, busy_cnt, done_cnt, done_cyc, anomalies, last_fall;
    logic [5:0] first_addr, last_addr;
    logic prev_req = 1'b0;

    task automatic clear_log();
        nreq = 0; nclr = 0; ack_idx = 0; wait_cnt = 0; busy_cnt = 0;
        done_cnt = 0; done_cyc = 0; anomalies = 0; last_fall = 0;
        first_addr = '0; last_addr = '0;
    endtask

    // Tracker + storage model, evaluated mid-cycle so DUT outputs are settled.
    initial begin
        clear_log();
        forever begin
            @(negedge clk);
            if (!flush_req && prev_req) last_fall = cyc;
            if (flush_req && !prev_req) begin
                if (nreq > 0 && flush_saddr == last_addr && (cyc - last_fall) != 1) anomalies++;
                if (nreq == 0) first_addr = flush_saddr;
                last_addr = flush_saddr;
                nreq++;
                if (cur_abort_at != 0) abort = (nreq == cur_abort_at);
            end else if (cur_abort_at != 0) begin
                abort = 1'b0;
            end
            if (flush_req && prev_req && flush_saddr != last_addr) anomalies++;
            if (flush_req) begin
                if (wait_cnt == cur_delay) begin
                    flush_ack = 1'b1;
                    flush_err = (ack_idx < 3) ? cur_errs[ack_idx] : 1'b0;
                    ack_idx++;
                    wait_cnt = 0;
                end else begin
                    flush_ack = 1'b0;
                    flush_err = 1'b0;
                    wait_cnt++;
                end
            end else begin
                flush_ack = force_ack;
                flush_err = 1'b0;
                wait_cnt  = 0;
            end
            if (clr_en) begin
                nclr++;
                if (clr_d !== 1'b0 || clr_saddr !== last_addr) anomalies++;
                map[clr_saddr] = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_req = flush_req;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] m, input int d, input logic [2:0] e,
                                input int ab, input bit fa, input int rs, input int rq,
                                input logic [5:0] f, input logic [5:0] l, input logic [6:0] c,
                                input bit er, input int lat, input logic [63:0] em);
        vec_t v;
        v.map = m; v.delay = d; v.errs = e; v.abort_at = ab; v.force_ack = fa;
        v.restart = rs; v.exp_reqs = rq; v.exp_first = f; v.exp_last = l;
        v.exp_cnt = c; v.exp_error = er; v.exp_lat = lat; v.exp_map = em;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int t0;
        @(negedge clk);
        #1;
        clear_log();
        map = v.map; cur_delay = v.delay; cur_errs = v.errs;
        cur_abort_at = v.abort_at; force_ack = v.force_ack;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        if (v.restart > 0) begin
            repeat (v.restart - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 1000 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        force_ack = 1'b0; cur_abort_at = 0; abort = 1'b0;
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " latency"}, done_cyc - t0, v.exp_lat);
        chk({tag, " busy_cycles"}, busy_cnt, v.exp_lat);
        chk({tag, " requests"}, nreq, v.exp_reqs);
        if (v.exp_reqs > 0) begin
            chk({tag, " first_saddr"}, first_addr, v.exp_first);
            chk({tag, " last_saddr"}, last_addr, v.exp_last);
        end
        chk({tag, " clears"}, nclr, v.exp_cnt);
        chk({tag, " flushed_cnt"}, flushed_cnt, v.exp_cnt);
        chk({tag, " error"}, error, v.exp_error);
        chk({tag, " bitmap"}, map, v.exp_map);
        chk({tag, " protocol"}, anomalies, 0);
        chk({tag, " idle"}, {busy, flush_req, clr_en, done}, 0);
    endtask

    localparam logic [63:0] ALL = '1;
    vec_t tbl[9];

    initial begin
        tbl[0] = mk(64'd1 << 5,  3, 3'b000, 0, 0, 0, 1,  6'd5,  6'd5,  7'd1,  0, 8,   '0);
        tbl[1] = mk((64'd1 << 63) | 64'd1, 0, 3'b000, 0, 0, 0, 2, 6'd0, 6'd63, 7'd2, 0, 8, '0);
        tbl[2] = mk('0,          0, 3'b000, 0, 0, 0, 0,  6'd0,  6'd0,  7'd0,  0, 2,   '0);
        tbl[3] = mk(64'd1 << 10, 0, 3'b111, 0, 0, 0, 3,  6'd10, 6'd10, 7'd0,  1, 7,   64'd1 << 10);
        tbl[4] = mk(64'd1 << 10, 0, 3'b011, 0, 0, 0, 3,  6'd10, 6'd10, 7'd1,  0, 9,   '0);
        tbl[5] = mk(ALL,         0, 3'b000, 2, 0, 0, 2,  6'd0,  6'd1,  7'd2,  0, 8,   ~64'h3);
        tbl[6] = mk(ALL,         0, 3'b000, 0, 0, 0, 64, 6'd0,  6'd63, 7'd64, 0, 194, '0);
        tbl[7] = mk(64'd1 << 2,  2, 3'b000, 0, 1, 0, 1,  6'd2,  6'd2,  7'd1,  0, 7,   '0);
        tbl[8] = mk(64'd1 << 3,  5, 3'b000, 0, 0, 3, 1,  6'd3,  6'd3,  7'd1,  0, 10,  '0);

        #2;
        chk("reset_outputs", {flush_req, flush_saddr, clr_en, clr_d, clr_saddr,
                              busy, done, error, flushed_cnt}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int unsigned i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Abort while idle must not carry into the next flush.
        @(negedge clk);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        run(mk(64'd1 << 7, 1, 3'b000, 0, 0, 0, 1, 6'd7, 6'd7, 7'd1, 0, 6, '0), "idle_abort");

        // Reset in the middle of a request.
        @(negedge clk);
        clear_log();
        map = ALL; cur_delay = 10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !flush_req; k++) @(negedge clk);
        chk("rst_req_seen", flush_req, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_drop", {flush_req, busy}, 0);
        chk("rst_all_outputs", {flush_req, flush_saddr, clr_en, clr_d, clr_saddr,
                                busy, done, error, flushed_cnt}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_no_clear", {nclr, map}, {32'd0, ALL});
        cur_delay = 0;
        run(mk(64'd1 << 5, 3, 3'b000, 0, 0, 0, 1, 6'd5, 6'd5, 7'd1, 0, 8, '0), "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
